// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: standard VGA timing constants and a helper deriving line/frame spans
package vga_timing_pkg;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;

    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FRONT  = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BACK   = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FRONT  = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BACK   = 23;

    typedef struct packed {
        int total;
        int beg;
        int fin;
    } span_t;

    // Order within a line/frame is sync, back porch, active, front porch.
    function automatic span_t span_calc(int active, int front, int sync, int back);
        span_t s;
        s.total = sync + back + active + front;
        s.beg   = sync + back;
        s.fin   = sync + back + active;
        return s;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: control inputs and timing outputs of the VGA timing generator
// master: generator side (i_Ce/i_Restart in; sync, valid, coords, strobes, frame count out)
// slave:  consumer side
interface vga_timing_gen_if #(parameter int COORD_W = 12);

    logic               i_Ce;
    logic               i_Restart;
    logic               o_HSync;
    logic               o_VSync;
    logic               o_valid;
    logic [COORD_W-1:0] o_x;
    logic [COORD_W-1:0] o_y;
    logic               o_line_start;
    logic               o_frame_start;
    logic [15:0]        o_frame_cnt;

    modport master (
        input  i_Ce, i_Restart,
        output o_HSync, o_VSync, o_valid, o_x, o_y, o_line_start, o_frame_start, o_frame_cnt
    );

    modport slave (
        output i_Ce, i_Restart,
        input  o_HSync, o_VSync, o_valid, o_x, o_y, o_line_start, o_frame_start, o_frame_cnt
    );

endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: ce-gated shift register with async active-low reset; DEPTH=0 passes through
// Ports: i_Clk, i_Rst_n, i_Ce (advance), i_d (input word), o_q (word DEPTH enabled edges old)
module vga_delay_line #(
    parameter int                WIDTH     = 1,
    parameter int                DEPTH     = 0,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        assign o_q = i_d;
    end else begin : g_shift
        logic [DEPTH*WIDTH-1:0] sr_q, sr_d;
        // Truncating the concatenation drops the oldest word: a one-word shift.
        always_comb sr_d = i_Ce ? (DEPTH*WIDTH)'({sr_q, i_d}) : sr_q;
        always_ff @(posedge i_Clk or negedge i_Rst_n)
            if (!i_Rst_n) sr_q <= {DEPTH{RESET_VAL}};
            else          sr_q <= sr_d;
        assign o_q = sr_q[DEPTH*WIDTH-1 -: WIDTH];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/position generator with frame counter and output delay
// Ports: i_Clk, i_Rst_n (async active-low), vga (master: i_Ce, i_Restart in; o_HSync, o_VSync,
//        o_valid, o_x, o_y, o_line_start, o_frame_start, o_frame_cnt out)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FRONT    = VGA640_H_FRONT,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BACK     = VGA640_H_BACK,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FRONT    = VGA640_V_FRONT,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BACK     = VGA640_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int COORD_W    = 12,
    parameter int DELAY      = 0
) (
    input logic               i_Clk,
    input logic               i_Rst_n,
    vga_timing_gen_if.master  vga
);

    localparam span_t H_SP = span_calc(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam span_t V_SP = span_calc(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    if (H_SP.total >= (1 << COORD_W) || V_SP.total >= (1 << COORD_W) || DELAY > 15 || DELAY < 0 ||
        H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_SP.total - 1);
    localparam logic [COORD_W-1:0] H_BEG  = COORD_W'(H_SP.beg);
    localparam logic [COORD_W-1:0] H_END  = COORD_W'(H_SP.fin);
    localparam logic [COORD_W-1:0] H_SYN  = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_SP.total - 1);
    localparam logic [COORD_W-1:0] V_BEG  = COORD_W'(V_SP.beg);
    localparam logic [COORD_W-1:0] V_END  = COORD_W'(V_SP.fin);
    localparam logic [COORD_W-1:0] V_SYN  = COORD_W'(V_SYNC);

    // Output bus: {hsync, vsync, valid, x, y, line_start, frame_start, frame_cnt}
    localparam int                 W       = 5 + 2 * COORD_W + 16;
    localparam logic [W-1:0]       RST_VEC = {~H_SYNC_POL, ~V_SYNC_POL, {(W-2){1'b0}}};

    logic [COORD_W-1:0] h_q, h_d, v_q, v_d, x, y;
    logic [15:0]        f_q, f_d;
    logic               h_wrap, f_wrap, valid;
    logic [W-1:0]       dec, out;

    always_comb begin
        h_wrap = h_q == H_LAST;
        f_wrap = h_wrap && v_q == V_LAST;
        h_d    = !vga.i_Ce ? h_q : (vga.i_Restart || h_wrap) ? '0 : h_q + 1'b1;
        v_d    = !vga.i_Ce ? v_q : (vga.i_Restart || f_wrap) ? '0 : h_wrap ? v_q + 1'b1 : v_q;
        f_d    = (vga.i_Ce && (vga.i_Restart || f_wrap)) ? f_q + 1'b1 : f_q;
        valid  = h_q >= H_BEG && h_q < H_END && v_q >= V_BEG && v_q < V_END;
        x      = valid ? h_q - H_BEG : '0;
        y      = valid ? v_q - V_BEG : '0;
        dec    = {(h_q < H_SYN) ? H_SYNC_POL : ~H_SYNC_POL,
                  (v_q < V_SYN) ? V_SYNC_POL : ~V_SYNC_POL,
                  valid, x, y, h_q == '0, h_q == '0 && v_q == '0, f_q};
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n)
        if (!i_Rst_n) begin
            h_q <= '0;
            v_q <= '0;
            f_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            f_q <= f_d;
        end

    // One mandatory register stage plus DELAY alignment stages, all ce-gated.
    vga_delay_line #(.WIDTH(W), .DEPTH(DELAY + 1), .RESET_VAL(RST_VEC)) u_dly (
        .i_Clk  (i_Clk),
        .i_Rst_n(i_Rst_n),
        .i_Ce   (vga.i_Ce),
        .i_d    (dec),
        .o_q    (out)
    );

    assign {vga.o_HSync, vga.o_VSync, vga.o_valid, vga.o_x, vga.o_y,
            vga.o_line_start, vga.o_frame_start, vga.o_frame_cnt} = out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a small-geometry timing generator, undelayed and delayed
module tb_vga_timing_gen;

    localparam int HS = 3, HBK = 2, HA = 8, HF = 2;
    localparam int VS = 2, VBK = 1, VA = 4, VF = 1;
    localparam int HT = 15, VT = 8;
    localparam int HBEG = 5, HEND = 13, VBEG = 3, VEND = 7;
    localparam int CW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic restart = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.COORD_W(CW)) b0 ();
    vga_timing_gen_if #(.COORD_W(CW)) b1 ();

    assign b0.i_Ce = ce;
    assign b1.i_Ce = ce;
    assign b0.i_Restart = restart;
    assign b1.i_Restart = restart;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COORD_W(CW), .DELAY(0)
    ) dut0 (.i_Clk(clk), .i_Rst_n(rst_n), .vga(b0));

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COORD_W(CW), .DELAY(3)
    ) dut1 (.i_Clk(clk), .i_Rst_n(rst_n), .vga(b1));

    logic [44:0] got0, got1;
    assign got0 = {b0.o_HSync, b0.o_VSync, b0.o_valid, b0.o_x, b0.o_y,
                   b0.o_line_start, b0.o_frame_start, b0.o_frame_cnt};
    assign got1 = {b1.o_HSync, b1.o_VSync, b1.o_valid, b1.o_x, b1.o_y,
                   b1.o_line_start, b1.o_frame_start, b1.o_frame_cnt};

    localparam logic [44:0] IDLE0 = {1'b1, 1'b1, 43'b0};
    localparam logic [44:0] IDLE1 = {1'b0, 1'b0, 43'b0};

    int          m_h, m_v;
    logic [15:0] m_f;
    logic [44:0] hist[$];

    function automatic logic [44:0] expv(int h, int v, logic [15:0] f, bit hp, bit vp);
        bit          val;
        logic [11:0] x, y;
        val = h >= HBEG && h < HEND && v >= VBEG && v < VEND;
        x = val ? 12'(h - HBEG) : 12'd0;
        y = val ? 12'(v - VBEG) : 12'd0;
        return {(h < HS) ? hp : ~hp, (v < VS) ? vp : ~vp, val, x, y, h == 0, h == 0 && v == 0, f};
    endfunction

    task automatic model_reset();
        m_h = 0;
        m_v = 0;
        m_f = '0;
        hist = {IDLE1, IDLE1, IDLE1};
    endtask

    // Expected outputs for the enabled edge about to complete, then advance the model position.
    task automatic model_edge(input bit rs, output logic [44:0] e0, output logic [44:0] e1);
        e0 = expv(m_h, m_v, m_f, 1'b0, 1'b0);
        hist.push_back(expv(m_h, m_v, m_f, 1'b1, 1'b1));
        e1 = hist.pop_front();
        if (rs) begin
            m_h = 0;
            m_v = 0;
            m_f = m_f + 16'd1;
        end else if (m_h == HT - 1) begin
            m_h = 0;
            if (m_v == VT - 1) begin
                m_v = 0;
                m_f = m_f + 16'd1;
            end else m_v = m_v + 1;
        end else m_h = m_h + 1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ce = 1'b0;
        restart = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce = 1'b1;
        restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (got0 !== IDLE0) begin
            fails++;
            $display("FAIL reset_dut0 got %h exp %h", got0, IDLE0);
        end
        tests++;
        if (got1 !== IDLE1) begin
            fails++;
            $display("FAIL reset_dut1 got %h exp %h", got1, IDLE1);
        end
    endtask

    task automatic test_sequence();
        logic [44:0] e0, e1;
        apply_reset();
        ce = 1'b1;
        for (int k = 0; k < 2 * HT * VT + 10; k++) begin
            @(posedge clk);
            #1;
            model_edge(1'b0, e0, e1);
            tests++;
            if (got0 !== e0) begin
                fails++;
                $display("FAIL seq_dut0 k=%0d got %h exp %h", k, got0, e0);
            end
            tests++;
            if (got1 !== e1) begin
                fails++;
                $display("FAIL seq_dut1 k=%0d got %h exp %h", k, got1, e1);
            end
            if (k == 0 || k == 120) begin
                tests++;
                if (!(b0.o_frame_start === 1'b1 && b0.o_line_start === 1'b1 && b0.o_frame_cnt === 16'(k / 120))) begin
                    fails++;
                    $display("FAIL frame_strobe k=%0d fs=%b ls=%b cnt=%0d", k, b0.o_frame_start, b0.o_line_start, b0.o_frame_cnt);
                end
            end
            if (k == 2 || k == 3) begin
                tests++;
                if (b0.o_HSync !== (k == 3)) begin
                    fails++;
                    $display("FAIL hsync_edge k=%0d got %b exp %b", k, b0.o_HSync, k == 3);
                end
            end
            if (k == 50) begin
                tests++;
                if (!(b0.o_valid === 1'b1 && b0.o_x === 12'd0 && b0.o_y === 12'd0)) begin
                    fails++;
                    $display("FAIL first_valid got v=%b x=%0d y=%0d exp v=1 x=0 y=0", b0.o_valid, b0.o_x, b0.o_y);
                end
            end
            if (k == 102 || k == 103) begin
                tests++;
                if (!(b0.o_valid === (k == 102) && b0.o_x === ((k == 102) ? 12'd7 : 12'd0) && b0.o_y === ((k == 102) ? 12'd3 : 12'd0))) begin
                    fails++;
                    $display("FAIL last_valid k=%0d got v=%b x=%0d y=%0d", k, b0.o_valid, b0.o_x, b0.o_y);
                end
            end
            if (k == 3 || k == 4) begin
                tests++;
                if (got1 !== ((k == 3) ? expv(0, 0, 16'd0, 1'b1, 1'b1) : expv(1, 0, 16'd0, 1'b1, 1'b1))) begin
                    fails++;
                    $display("FAIL delay_align k=%0d got %h", k, got1);
                end
            end
        end
    endtask

    task automatic test_ce_gating();
        logic [44:0] e0, e1;
        apply_reset();
        for (int k = 0; k < HT * VT + 20; k++) begin
            ce = 1'b1;
            @(posedge clk);
            #1;
            model_edge(1'b0, e0, e1);
            tests++;
            if (got0 !== e0 || got1 !== e1) begin
                fails++;
                $display("FAIL ce_on k=%0d got %h/%h exp %h/%h", k, got0, got1, e0, e1);
            end
            ce = 1'b0;
            @(posedge clk);
            #1;
            tests++;
            if (got0 !== e0 || got1 !== e1) begin
                fails++;
                $display("FAIL ce_hold k=%0d got %h/%h exp %h/%h", k, got0, got1, e0, e1);
            end
        end
    endtask

    task automatic test_restart();
        logic [44:0] e0, e1;
        apply_reset();
        ce = 1'b1;
        for (int k = 0; k < 200 && !(m_h == 7 && m_v == 4); k++) begin
            @(posedge clk);
            #1;
            model_edge(1'b0, e0, e1);
        end
        restart = 1'b1;
        @(posedge clk);
        #1;
        model_edge(1'b1, e0, e1);
        restart = 1'b0;
        tests++;
        if (got0 !== e0 || b0.o_x !== 12'd2 || b0.o_y !== 12'd1) begin
            fails++;
            $display("FAIL restart_edge got %h exp %h", got0, e0);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            model_edge(1'b0, e0, e1);
            tests++;
            if (got0 !== e0 || got1 !== e1) begin
                fails++;
                $display("FAIL restart_seq k=%0d got %h/%h exp %h/%h", k, got0, got1, e0, e1);
            end
            if (k == 0) begin
                tests++;
                if (!(b0.o_frame_start === 1'b1 && b0.o_frame_cnt === 16'd1 && b0.o_HSync === 1'b0)) begin
                    fails++;
                    $display("FAIL restart_origin fs=%b cnt=%0d hs=%b exp fs=1 cnt=1 hs=0", b0.o_frame_start, b0.o_frame_cnt, b0.o_HSync);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [44:0] e0, e1;
        bit          found;
        apply_reset();
        ce = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk);
            #1;
            model_edge(1'b0, e0, e1);
            found = b0.o_valid === 1'b1 && b0.o_x === 12'd5;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL async_find got no valid x=5 within 200 edges");
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (got0 !== IDLE0 || got1 !== IDLE1) begin
            fails++;
            $display("FAIL async_reset got %h/%h exp %h/%h", got0, got1, IDLE0, IDLE1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        model_edge(1'b0, e0, e1);
        tests++;
        if (got0 !== expv(0, 0, 16'd0, 1'b0, 1'b0) || got1 !== IDLE1) begin
            fails++;
            $display("FAIL async_release got %h/%h exp %h/%h", got0, got1, e0, e1);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_ce_gating();
        test_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Produces HSync/VSync, an active-video flag, pixel coordinates, and line/frame strobes for any porch/sync/active geometry, with configurable sync polarity.
- Advances on a pixel-clock enable and has an optional output delay line to align sync with downstream pixel pipelines. Supports a synchronous frame restart and a 16-bit frame counter.
- Sits between the board clock and pattern/framebuffer logic that drives VGA_R/G/B.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, back porch (lines)
H_SYNC_POL, 0, asserted level of o_HSync (0 = active-low)
V_SYNC_POL, 0, asserted level of o_VSync
COORD_W, 12, width of o_x/o_y and the internal counters
DELAY, 0, extra output pipeline stages (0..15)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Ce  in  1  pixel enable; all state advances only on edges with i_Ce=1
i_Restart  in  1  synchronous; with i_Ce=1, forces the counter to position (0,0)
o_HSync  out  1  horizontal sync, polarity H_SYNC_POL
o_VSync  out  1  vertical sync, polarity V_SYNC_POL
o_valid  out  1  active video
o_x  out  COORD_W  active-region column; 0 when o_valid=0
o_y  out  COORD_W  active-region row; 0 when o_valid=0
o_line_start  out  1  high for the position with h=0
o_frame_start  out  1  high for the position with h=0, v=0
o_frame_cnt  out  16  frame index of the current output position

Behaviour:
- Reset is asynchronous and active-low, on i_Rst_n. Clock is i_Clk.
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise.
- Line order: sync, back porch, active, front porch. Frame order is the same.
- H_BEGIN = H_SYNC+H_BACK, H_END = H_BEGIN+H_ACTIVE. V_BEGIN and V_END are defined the same way.
- Counter (h,v):
  - h wraps from H_TOTAL-1 to 0, and v increments on that wrap.
  - v wraps from V_TOTAL-1 to 0.
  - Frame count increments (mod 2^16) on each v wrap.
- i_Restart: on an enabled edge, h and v go to 0 and the frame count increments, regardless of position. Restart takes priority over normal advance.
- Decode, evaluated on the current (h,v):
  - HSync is asserted when h < H_SYNC.
  - VSync is asserted when v < V_SYNC.
  - valid = (H_BEGIN <= h < H_END) && (V_BEGIN <= v < V_END).
  - x = h-H_BEGIN and y = v-V_BEGIN when valid, else 0.
- Decoded values are registered on the same enabled edge that advances the counter. Latency is 1 enabled edge, then DELAY further enabled-edge stages. Every output is delayed identically, so outputs are mutually coherent.
- After reset, the first enabled edge presents position (0,0): frame_start=1, line_start=1, frame_cnt=0.
- i_Ce=0: counters, delay stages and all outputs hold. Consumers qualify strobes with i_Ce.
- Reset values (counters and every delay stage):
  - h=v=0, frame count 0.
  - o_HSync=~H_SYNC_POL, o_VSync=~V_SYNC_POL.
  - o_valid=0, o_x=o_y=0, both strobes 0, o_frame_cnt=0.
- Reset mid-frame clears everything immediately, with no clock edge required.
- Elaboration error if H_TOTAL or V_TOTAL is >= 2^COORD_W, if DELAY > 15, or if any timing parameter is 0 (polarity parameters excepted).

Decomposition:
- Package vga_timing_pkg: default 640x480@60 and 800x600@60 timing constants, plus a function computing totals/BEGIN/END.
- Sub-module vga_delay_line: a ce-gated shift register with parameters WIDTH, DEPTH and RESET_VAL, with async active-low reset. It carries the packed {sync, valid, x, y, strobes, frame_cnt} bus. DEPTH=0 is a pass-through.

Test Plan:
- Defaults, reset then i_Ce=1 held (output index k = k-th enabled edge, starting at 0):
  - o_HSync=0 for k=0..95 and 1 at k=96.
  - o_VSync=0 for k<1600.
  - First o_valid at k=28144 with x=0, y=0.
  - Last valid at k=411983 with x=639, y=479.
- Defaults, line and frame strobes: o_line_start at every k multiple of 800; o_frame_start at k=0 and k=420000, with o_frame_cnt 0 then 1; o_frame_cnt wraps 65535->0.
- i_Ce alternating 1/0: outputs hold on i_Ce=0 cycles. The output sequence, indexed by enabled edges, is identical to the first scenario.
- i_Restart pulsed while counter is at h=300, v=100: the next output (k+1) shows h=0, v=0 decode with o_frame_start=1 and o_frame_cnt incremented by 1.
- DELAY=3, H_SYNC_POL=1, V_SYNC_POL=1:
  - Outputs 0..2 hold idle values (o_HSync=0, o_VSync=0).
  - Then the first-scenario sequence, shifted by 3 enabled edges, with sync levels inverted.
- i_Rst_n driven low asynchronously during active video (o_valid=1, x=200): outputs go to reset values before the next i_Clk edge. Release gives the first enabled output at (0,0).
